// File: rtl/mem_io_responder.sv
// Memory-side responder: decodes requests to block RAM or memory-mapped I/O,
// performs writes, and returns read data one cycle after the read strobe.
module mem_io_responder #(
    parameter int unsigned       ADDR_W  = 16,
    parameter int unsigned       DATA_W  = 16,
    parameter logic [ADDR_W-1:0] IO_BASE = 16'hFF00,
    parameter int unsigned       SW_W    = 10,
    parameter int unsigned       BTN_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [SW_W-1:0]   sw_in,
    input  logic [BTN_W-1:0]  btn_in,
    output logic [SW_W-1:0]   led_out,
    output logic [DATA_W-1:0] hex_out
);

    typedef enum logic [2:0] {
        SEL_RAM, SEL_LED, SEL_HEX, SEL_SW, SEL_BTN, SEL_TLO, SEL_THI, SEL_NONE
    } sel_e;

    logic              is_io;
    logic [ADDR_W-1:0] io_off;
    logic              rd_en;
    sel_e              sel_d, sel_q;
    logic              rd_pend_q;
    logic [DATA_W-1:0] rd_data_d, rd_data_q;
    logic [SW_W-1:0]   led_q, sw_s1_q, sw_s2_q;
    logic [DATA_W-1:0] hex_q;
    logic [BTN_W-1:0]  btn_s1_q, btn_s2_q, btn_prev_q, btn_lat_d, btn_lat_q, btn_rise;
    logic [31:0]       tick_q;
    logic [15:0]       snap_d, snap_q;

    assign is_io     = (req_addr >= IO_BASE);
    assign io_off    = req_addr - IO_BASE;
    // A simultaneous write suppresses the read entirely, including its side effects.
    assign rd_en     = req_rd & ~req_wr;
    assign ram_we    = reset & req_wr & ~is_io;
    assign ram_addr  = req_addr;
    assign ram_wdata = req_wdata;
    assign btn_rise  = btn_s2_q & ~btn_prev_q;

    assign rd_data = rd_data_q;
    assign led_out = led_q;
    assign hex_out = hex_q;

    always_comb begin
        sel_d = SEL_NONE;
        if (!is_io) begin
            sel_d = SEL_RAM;
        end else begin
            case (io_off)
                ADDR_W'(0): sel_d = SEL_LED;
                ADDR_W'(1): sel_d = SEL_HEX;
                ADDR_W'(2): sel_d = SEL_SW;
                ADDR_W'(3): sel_d = SEL_BTN;
                ADDR_W'(4): sel_d = SEL_TLO;
                ADDR_W'(5): sel_d = SEL_THI;
                default:    sel_d = SEL_NONE;
            endcase
        end
    end

    // Read side effects (latch clear, snapshot) take effect with the data load.
    always_comb begin
        rd_data_d = rd_data_q;
        btn_lat_d = btn_lat_q;
        snap_d    = snap_q;
        if (rd_pend_q) begin
            case (sel_q)
                SEL_RAM: rd_data_d = ram_rdata;
                SEL_LED: rd_data_d = DATA_W'(led_q);
                SEL_HEX: rd_data_d = hex_q;
                SEL_SW:  rd_data_d = DATA_W'(sw_s2_q);
                SEL_BTN: begin
                    rd_data_d = DATA_W'(btn_lat_q);
                    btn_lat_d = '0;
                end
                SEL_TLO: begin
                    rd_data_d = DATA_W'(tick_q[15:0]);
                    snap_d    = tick_q[31:16];
                end
                SEL_THI: rd_data_d = DATA_W'(snap_q);
                default: rd_data_d = '0;
            endcase
        end
        // A new edge in the clearing cycle survives the clear.
        btn_lat_d = btn_lat_d | btn_rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend_q  <= 1'b0;
            sel_q      <= SEL_RAM;
            rd_data_q  <= '0;
            led_q      <= '0;
            hex_q      <= '0;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            btn_prev_q <= '0;
            btn_lat_q  <= '0;
            tick_q     <= '0;
            snap_q     <= '0;
        end else begin
            rd_pend_q  <= rd_en;
            sel_q      <= sel_d;
            rd_data_q  <= rd_data_d;
            sw_s1_q    <= sw_in;
            sw_s2_q    <= sw_s1_q;
            btn_s1_q   <= btn_in;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
            btn_lat_q  <= btn_lat_d;
            tick_q     <= tick_q + 32'd1;
            snap_q     <= snap_d;
            if (req_wr && sel_d == SEL_LED) led_q <= req_wdata[SW_W-1:0];
            if (req_wr && sel_d == SEL_HEX) hex_q <= req_wdata;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: I/O register table, randomized
// transactions against a transaction-level model, and directed corner sequences.
module tb_mem_io_responder;

    localparam logic [15:0] IO_BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] req_addr, req_wdata, rd_data, ram_addr, ram_wdata, ram_rdata, hex_out;
    logic        req_rd, req_wr, ram_we;
    logic [9:0]  sw_in, led_out;
    logic [3:0]  btn_in;

    always #5 clk = ~clk;

    mem_io_responder #(
        .ADDR_W(16), .DATA_W(16), .IO_BASE(16'hFF00), .SW_W(10), .BTN_W(4)
    ) dut (
        .clk(clk), .reset(reset), .req_addr(req_addr), .req_rd(req_rd),
        .req_wr(req_wr), .req_wdata(req_wdata), .rd_data(rd_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .sw_in(sw_in), .btn_in(btn_in),
        .led_out(led_out), .hex_out(hex_out)
    );

    // Synchronous block RAM attached to the responder.
    bit [15:0] ram [0:65535];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    // Transaction-level reference state.
    bit [15:0]   mem_m [0:65535];
    logic [9:0]  led_m, sw_m;
    logic [15:0] hex_m, snap_m, last_rd;
    logic [3:0]  btn_m;
    logic [31:0] ncyc;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_rd;
        logic [9:0]  exp_led;
        logic [15:0] exp_hex;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) ncyc = ncyc + 32'd1;
        #1;
    endtask

    task automatic write_op(input logic [15:0] a, input logic [15:0] d);
        req_addr = a; req_wdata = d; req_wr = 1'b1;
        #1;
        chk("ram_we_on_write", {31'b0, ram_we}, {31'b0, (a < IO_BASE)});
        step();
        req_wr = 1'b0;
        if (a < IO_BASE) mem_m[a] = d;
        else if (a == IO_BASE) led_m = d[9:0];
        else if (a == IO_BASE + 16'd1) hex_m = d;
        chk("hold_after_write", {16'b0, rd_data}, {16'b0, last_rd});
    endtask

    task automatic read_model(input logic [15:0] a, input string name);
        logic [15:0] exp, off;
        logic [31:0] t;
        req_addr = a; req_rd = 1'b1;
        step();
        req_rd = 1'b0;
        chk({name, "_hold"}, {16'b0, rd_data}, {16'b0, last_rd});
        t   = ncyc;
        off = a - IO_BASE;
        if (a < IO_BASE) exp = mem_m[a];
        else begin
            case (off)
                16'd0: exp = {6'b0, led_m};
                16'd1: exp = hex_m;
                16'd2: exp = {6'b0, sw_m};
                16'd3: begin exp = {12'b0, btn_m}; btn_m = 4'b0; end
                16'd4: begin exp = t[15:0]; snap_m = t[31:16]; end
                16'd5: exp = snap_m;
                default: exp = 16'h0000;
            endcase
        end
        step();
        chk(name, {16'b0, rd_data}, {16'b0, exp});
        last_rd = exp;
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 16'($urandom_range(0, 31));
            2:       return IO_BASE + 16'($urandom_range(0, 7));
            default: return ($urandom_range(0, 1) != 0) ? 16'hFEFF : 16'hFFFF;
        endcase
    endfunction

    initial begin
        tbl[0]  = '{1'b1, 16'hFF00, 16'h03FF, 16'h0000, 10'h3FF, 16'h0000};
        tbl[1]  = '{1'b0, 16'hFF00, 16'h0000, 16'h03FF, 10'h3FF, 16'h0000};
        tbl[2]  = '{1'b1, 16'hFF02, 16'h1234, 16'h0000, 10'h3FF, 16'h0000};
        tbl[3]  = '{1'b0, 16'hFF02, 16'h0000, 16'h02A5, 10'h3FF, 16'h0000};
        tbl[4]  = '{1'b1, 16'hFF01, 16'hBEEF, 16'h0000, 10'h3FF, 16'hBEEF};
        tbl[5]  = '{1'b0, 16'hFF01, 16'h0000, 16'hBEEF, 10'h3FF, 16'hBEEF};
        tbl[6]  = '{1'b1, 16'hFF00, 16'hF0C3, 16'h0000, 10'h0C3, 16'hBEEF};
        tbl[7]  = '{1'b0, 16'hFF00, 16'h0000, 16'h00C3, 10'h0C3, 16'hBEEF};
        tbl[8]  = '{1'b1, 16'hFF06, 16'h5555, 16'h0000, 10'h0C3, 16'hBEEF};
        tbl[9]  = '{1'b0, 16'hFF06, 16'h0000, 16'h0000, 10'h0C3, 16'hBEEF};
        tbl[10] = '{1'b1, 16'hFF05, 16'h7777, 16'h0000, 10'h0C3, 16'hBEEF};
        tbl[11] = '{1'b0, 16'hFF05, 16'h0000, 16'h0000, 10'h0C3, 16'hBEEF};

        reset = 1'b1; req_addr = 16'h0010; req_rd = 1'b0; req_wr = 1'b1;
        req_wdata = 16'hDEAD; sw_in = 10'h2A5; btn_in = 4'b0;
        led_m = '0; hex_m = '0; snap_m = '0; btn_m = '0; last_rd = '0; ncyc = '0;
        sw_m = 10'h2A5;
        #1 reset = 1'b0;
        repeat (3) step();
        chk("reset_ram_we", {31'b0, ram_we}, 32'd0);
        chk("reset_rd_data", {16'b0, rd_data}, 32'd0);
        chk("reset_led", {22'b0, led_out}, 32'd0);
        chk("reset_hex", {16'b0, hex_out}, 32'd0);
        req_wr = 1'b0;
        reset = 1'b1;
        repeat (2) step();

        // I/O register table
        for (int unsigned i = 0; i < 12; i++) begin
            if (tbl[i].wr) begin
                write_op(tbl[i].addr, tbl[i].data);
            end else begin
                req_addr = tbl[i].addr; req_rd = 1'b1;
                step();
                req_rd = 1'b0;
                step();
                chk($sformatf("tbl%0d_rd", i), {16'b0, rd_data}, {16'b0, tbl[i].exp_rd});
                last_rd = tbl[i].exp_rd;
            end
            chk($sformatf("tbl%0d_led", i), {22'b0, led_out}, {22'b0, tbl[i].exp_led});
            chk($sformatf("tbl%0d_hex", i), {16'b0, hex_out}, {16'b0, tbl[i].exp_hex});
        end

        // Randomized transactions
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2:    write_op(pick_addr(), 16'($urandom));
                3, 4, 5, 6: read_model(pick_addr(), "rand_read");
                7: begin
                    sw_in = 10'($urandom);
                    step(); step();
                    sw_m = sw_in;
                end
                8: write_op(IO_BASE + 16'($urandom_range(0, 1)), 16'($urandom));
                default: begin
                    step();
                    chk("rand_hold", {16'b0, rd_data}, {16'b0, last_rd});
                end
            endcase
        end

        // RAM write then read, with the held value checked afterwards
        write_op(16'h0010, 16'hBEEF);
        #1 chk("ram_we_pulse_end", {31'b0, ram_we}, 32'd0);
        read_model(16'h0010, "ram_rd_beef");
        step();
        chk("ram_rd_held", {16'b0, rd_data}, 32'h0000BEEF);

        // Button latch: sticky, read-clear
        btn_in = 4'b0010; repeat (3) step(); btn_in = 4'b0; repeat (3) step();
        btn_m = 4'b0010;
        read_model(IO_BASE + 16'd3, "btn_first");
        read_model(IO_BASE + 16'd3, "btn_second");

        // Rising edge arriving in the clearing cycle
        btn_in = 4'b0001; repeat (3) step(); btn_in = 4'b0; repeat (3) step();
        btn_m = 4'b0001;
        btn_in = 4'b0100; step();
        read_model(IO_BASE + 16'd3, "btn_edge_on_clear");
        btn_m = 4'b0100;
        read_model(IO_BASE + 16'd3, "btn_edge_kept");
        btn_in = 4'b0; repeat (3) step();

        // Read and write together on the latch: write wins, no read-clear
        btn_in = 4'hF; repeat (4) step();
        btn_m = 4'hF;
        req_addr = IO_BASE + 16'd3; req_wdata = 16'h0000; req_rd = 1'b1; req_wr = 1'b1;
        #1 chk("rdwr_ram_we", {31'b0, ram_we}, 32'd0);
        step();
        req_rd = 1'b0; req_wr = 1'b0;
        step();
        chk("rdwr_rd_unchanged", {16'b0, rd_data}, {16'b0, last_rd});
        read_model(IO_BASE + 16'd3, "btn_after_rdwr");
        read_model(IO_BASE + 16'd3, "btn_after_clear");
        btn_in = 4'b0; repeat (3) step();

        // Reset during an outstanding read, with a RAM write pending
        write_op(IO_BASE, 16'h0155);
        write_op(IO_BASE + 16'd1, 16'h1234);
        req_addr = IO_BASE + 16'd1; req_rd = 1'b1;
        step();
        req_rd = 1'b0; req_addr = 16'h0020; req_wdata = 16'hAAAA; req_wr = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_rd_data", {16'b0, rd_data}, 32'd0);
        chk("rst_led", {22'b0, led_out}, 32'd0);
        chk("rst_hex", {16'b0, hex_out}, 32'd0);
        chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
        ncyc = '0; led_m = '0; hex_m = '0; snap_m = '0; btn_m = '0; last_rd = '0;
        step();
        req_wr = 1'b0;
        reset = 1'b1;
        step();
        chk("rst_pending_dropped", {16'b0, rd_data}, 32'd0);
        step(); step();
        read_model(16'h0020, "ram_not_written");

        // Tick counter coherent 32-bit read
        while (ncyc < 32'h0001_0005) step();
        read_model(IO_BASE + 16'd4, "tick_lo");
        read_model(IO_BASE + 16'd5, "tick_hi");
        chk("tick_hi_is_1", {16'b0, rd_data}, 32'd1);
        repeat (50) step();
        read_model(IO_BASE + 16'd5, "tick_hi_stable");
        read_model(IO_BASE + 16'd2, "sw_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
